// File: rtl/fir_coeff_loader.sv
// Coefficient-load sequencer for the 4-bank FIR datapath.
// Streams host coefficients into the FIR coefficient RAM and zero-pads the tap set to a multiple of 4.
module fir_coeff_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int MAX_COEFF = 63
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iNumOfCoeff,
  input  logic              iFirIdle,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeff,
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic [ADDR_W-1:0] oNumOfCoeff,
  output logic              oDone,
  output logic              oErr
);

  typedef enum logic [1:0] {IDLE, PREP, WRITE, DONE} stateT;

  localparam logic [ADDR_W:0] MaxCoeffW = (ADDR_W+1)'(MAX_COEFF);
  localparam logic [ADDR_W:0] Three     = (ADDR_W+1)'(3);
  localparam logic [ADDR_W:0] One       = (ADDR_W+1)'(1);

  stateT           state;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] padTotal;
  logic [ADDR_W:0] reqCount;
  logic [ADDR_W:0] numExt;
  logic            startOk;

  // idx and the padded total carry one extra bit so a 63-tap set can reach 64 without wrapping
  assign reqCount    = {1'b0, iNumOfCoeff};
  assign numExt      = {1'b0, oNumOfCoeff};
  assign startOk     = iFirIdle && (reqCount != '0) && (reqCount <= MaxCoeffW);
  assign oCoeffReady = (state == WRITE) && (idx < numExt);

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state            <= IDLE;
      idx              <= '0;
      padTotal         <= '0;
      oCoeffUpdateFlag <= 1'b0;
      oAddrRam         <= '0;
      oWrDtRam         <= '0;
      oNumOfCoeff      <= '0;
      oDone            <= 1'b0;
      oErr             <= 1'b0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            if (startOk) begin
              oNumOfCoeff      <= iNumOfCoeff;
              padTotal         <= (reqCount + Three) & ~Three;
              idx              <= '0;
              oCoeffUpdateFlag <= 1'b1;
              oAddrRam         <= '0;
              oWrDtRam         <= '0;
              state            <= PREP;
            end else begin
              oErr <= 1'b1;
            end
          end
        end
        PREP: state <= WRITE;
        WRITE: begin
          // Once idx reaches the padded total the last word is already on the bus
          if (idx == padTotal) begin
            oCoeffUpdateFlag <= 1'b0;
            oDone            <= 1'b1;
            state            <= DONE;
          end else if (idx >= numExt) begin
            oAddrRam <= idx[ADDR_W-1:0];
            oWrDtRam <= '0;
            idx      <= idx + One;
          end else if (iCoeffValid && oCoeffReady) begin
            oAddrRam <= idx[ADDR_W-1:0];
            oWrDtRam <= iCoeff;
            idx      <= idx + One;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: a session-level reference model predicts every output each cycle,
// and an image of the coefficient RAM built from the write bus is compared with the host data at session end.
module tb_fir_coeff_loader;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          iClk12M;
  logic          iRst;
  logic          iStart;
  logic [AW-1:0] iNumOfCoeff;
  logic          iFirIdle;
  logic          iCoeffValid;
  logic [DW-1:0] iCoeff;
  logic          oCoeffReady;
  logic          oCoeffUpdateFlag;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWrDtRam;
  logic [AW-1:0] oNumOfCoeff;
  logic          oDone;
  logic          oErr;

  fir_coeff_loader #(.DATA_W(DW), .ADDR_W(AW), .MAX_COEFF(63)) dut (
    .iClk12M(iClk12M), .iRst(iRst), .iStart(iStart), .iNumOfCoeff(iNumOfCoeff),
    .iFirIdle(iFirIdle), .iCoeffValid(iCoeffValid), .iCoeff(iCoeff),
    .oCoeffReady(oCoeffReady), .oCoeffUpdateFlag(oCoeffUpdateFlag), .oAddrRam(oAddrRam),
    .oWrDtRam(oWrDtRam), .oNumOfCoeff(oNumOfCoeff), .oDone(oDone), .oErr(oErr)
  );

  initial iClk12M = 1'b0;
  always #41 iClk12M = ~iClk12M;

  int checks = 0;
  int failures = 0;

  // Session-level model: phase 0 idle, 1 flag-setup cycle, 2 writing, 3 done pulse
  int        mPhase = 0;
  int        mNext = 0;
  int        mN = 0;
  int        mP = 0;
  logic      mFlag = 0, mDone = 0, mErr = 0;
  int        mAddr = 0, mData = 0, mNum = 0;

  logic [DW-1:0] hostData [64];
  logic [DW-1:0] ramImg [64];
  int flagCycles = 0;
  int maxAddr = 0;
  int doneSeen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic start, input logic [AW-1:0] n,
                           input logic idle, input logic valid, input logic [DW-1:0] coeff);
    if (rst) begin
      mPhase = 0; mNext = 0; mN = 0; mP = 0;
      mFlag = 0; mDone = 0; mErr = 0; mAddr = 0; mData = 0; mNum = 0;
    end else begin
      mDone = 0;
      mErr  = 0;
      case (mPhase)
        0: if (start) begin
             if (idle && n >= 1 && n <= 63) begin
               mN = n; mP = ((int'(n) + 3) / 4) * 4; mNext = 0;
               mFlag = 1; mAddr = 0; mData = 0; mNum = n; mPhase = 1;
             end else mErr = 1;
           end
        1: mPhase = 2;
        2: if (mNext == mP) begin
             mPhase = 3; mFlag = 0; mDone = 1;
           end else if (mNext >= mN) begin
             mAddr = mNext; mData = 0; mNext++;
           end else if (valid) begin
             mAddr = mNext; mData = coeff; mNext++;
           end
        default: mPhase = 0;
      endcase
    end
  endtask

  task automatic checkOutput();
    chk("ready", {31'b0, oCoeffReady}, (mPhase == 2 && mNext < mN) ? 32'd1 : 32'd0);
    chk("flag",  {31'b0, oCoeffUpdateFlag}, {31'b0, mFlag});
    chk("addr",  {26'b0, oAddrRam}, mAddr);
    chk("data",  {16'b0, oWrDtRam}, mData);
    chk("num",   {26'b0, oNumOfCoeff}, mNum);
    chk("done",  {31'b0, oDone}, {31'b0, mDone});
    chk("err",   {31'b0, oErr}, {31'b0, mErr});
    if (oCoeffUpdateFlag === 1'b1) begin
      ramImg[oAddrRam] = oWrDtRam;
      flagCycles++;
      if (int'(oAddrRam) > maxAddr) maxAddr = oAddrRam;
    end
    if (oDone === 1'b1) doneSeen++;
  endtask

  task automatic applyStimulus(input logic rst, input logic start, input logic [AW-1:0] n,
                               input logic idle, input logic valid, input logic [DW-1:0] coeff);
    iRst = rst; iStart = start; iNumOfCoeff = n; iFirIdle = idle;
    iCoeffValid = valid; iCoeff = coeff;
    modelStep(rst, start, n, idle, valid, coeff);
    @(posedge iClk12M);
    @(negedge iClk12M);
    checkOutput();
  endtask

  // mode 0: valid always high; 1: random valid/start/idle; 2: two-cycle valid gap before coefficient 2
  task automatic runSession(input int n, input logic idle, input int mode, input int rstAfter,
                            input logic presetData);
    int budget;
    int gap;
    logic accepted;
    logic v, s, r, fi;
    logic [DW-1:0] d;
    if (!presetData)
      for (int i = 0; i < 64; i++) hostData[i] = DW'($urandom);
    for (int i = 0; i < 64; i++) ramImg[i] = 16'hDEAD;
    flagCycles = 0; maxAddr = 0; doneSeen = 0; gap = 2; budget = 0;
    applyStimulus(0, 1, AW'(n), idle, 0, DW'($urandom));
    accepted = (mPhase == 1);
    while (mPhase != 0 && budget < 400) begin
      budget++;
      v = 1; s = 0; fi = 1;
      if (mode == 1) begin
        v  = ($urandom_range(0, 3) != 0);
        s  = ($urandom_range(0, 7) == 0);
        fi = $urandom_range(0, 1);
      end
      if (mode == 2 && mPhase == 2 && mNext == 2 && gap > 0) begin
        v = 0; gap--;
      end
      r = (rstAfter > 0 && mPhase == 2 && mNext == rstAfter);
      d = (mNext < mN) ? hostData[mNext] : DW'($urandom);
      applyStimulus(r, s, AW'($urandom_range(0, 63)), fi, v, d);
    end
    if (budget >= 400) begin
      failures++;
      $display("[TB] FAIL timeout: session n=%0d did not finish, got phase %0d, expected 0", n, mPhase);
    end
    if (accepted && rstAfter == 0) begin
      chk("doneCount", doneSeen, 1);
      for (int i = 0; i < mP; i++)
        chk($sformatf("ram[%0d]", i), {16'b0, ramImg[i]}, (i < n) ? {16'b0, hostData[i]} : 32'd0);
    end
  endtask

  initial begin
    $display("[TB] fir_coeff_loader bench starting");
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    chk("rstFlag", {31'b0, oCoeffUpdateFlag}, 0);
    chk("rstAddr", {26'b0, oAddrRam}, 0);
    chk("rstNum",  {26'b0, oNumOfCoeff}, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    hostData[0] = 16'h0011; hostData[1] = 16'h0022;
    hostData[2] = 16'h0033; hostData[3] = 16'h0044;
    runSession(4, 1, 0, 0, 1);
    chk("t1FlagCycles", flagCycles, 6);
    chk("t1Ram0", {16'b0, ramImg[0]}, 32'h0011);
    chk("t1Ram3", {16'b0, ramImg[3]}, 32'h0044);
    chk("t1Num", {26'b0, oNumOfCoeff}, 4);
    applyStimulus(0, 0, 0, 1, 0, 0);

    runSession(5, 1, 0, 0, 0);
    chk("t2MaxAddr", maxAddr, 7);
    chk("t2FlagCycles", flagCycles, 10);
    applyStimulus(0, 0, 0, 1, 0, 0);

    runSession(3, 1, 2, 0, 0);
    chk("t3MaxAddr", maxAddr, 3);
    chk("t3Ram3", {16'b0, ramImg[3]}, 0);

    applyStimulus(0, 1, 0, 1, 0, 0);
    chk("t4ErrN0", {31'b0, oErr}, 1);
    chk("t4FlagN0", {31'b0, oCoeffUpdateFlag}, 0);
    applyStimulus(0, 1, 6, 0, 0, 0);
    chk("t4ErrBusy", {31'b0, oErr}, 1);
    applyStimulus(0, 0, 6, 1, 0, 0);
    chk("t4ErrClear", {31'b0, oErr}, 0);

    runSession(63, 1, 0, 0, 0);
    chk("t5MaxAddr", maxAddr, 63);
    chk("t5Ram63", {16'b0, ramImg[63]}, 0);
    chk("t5Num", {26'b0, oNumOfCoeff}, 63);

    runSession(8, 1, 0, 2, 0);
    chk("t6Flag", {31'b0, oCoeffUpdateFlag}, 0);
    chk("t6Num", {26'b0, oNumOfCoeff}, 0);
    chk("t6Ready", {31'b0, oCoeffReady}, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runSession(2, 1, 0, 0, 0);
    chk("t6Ram1", {16'b0, ramImg[1]}, {16'b0, hostData[1]});

    for (int k = 0; k < 25; k++) begin
      runSession($urandom_range(0, 63), $urandom_range(0, 4) != 0, 1, 0, 0);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        applyStimulus(0, 0, 0, 1, $urandom_range(0, 1), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
